// File: rtl/sorted_merge8.sv
// rtl/sorted_merge8.sv - stable two-way merge of two ascending 4-word lists into an 8-word stream
module sorted_merge8 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              done
);

    typedef enum logic {IDLE, MERGE} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] a_q [4];
    logic [DATA_W-1:0] b_q [4];
    logic [2:0]        ia, ib;
    logic [3:0]        count;
    logic              adv, capture, load, finish, take_b;
    logic [DATA_W-1:0] a_head, b_head;

    // The output register may be refilled when it is empty or being drained this cycle.
    assign adv    = !out_valid || out_ready;
    assign a_head = a_q[ia[1:0]];
    assign b_head = b_q[ib[1:0]];

    // Pick the source of the next word: an exhausted list forces the other; ties go to A.
    always_comb begin
        take_b = 1'b0;
        if (ia == 3'd4) begin
            take_b = 1'b1;
        end else if (ib == 3'd4) begin
            take_b = 1'b0;
        end else begin
            take_b = (a_head > b_head);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        capture  = 1'b0;
        load     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    capture = 1'b1;
                    state_n = MERGE;
                end
            end
            MERGE: begin
                if (adv) begin
                    if (count != 4'd8) begin
                        load = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture the quad pair; later input changes never reach these registers.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            a_q[0] <= a0;
            a_q[1] <= a1;
            a_q[2] <= a2;
            a_q[3] <= a3;
            b_q[0] <= b0;
            b_q[1] <= b1;
            b_q[2] <= b2;
            b_q[3] <= b3;
        end
    end

    // Merge pointers, word counter, output register and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ia        <= 3'd0;
            ib        <= 3'd0;
            count     <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                out_valid <= 1'b1;
                out_last  <= (count == 4'd7);
                count     <= count + 4'd1;
                out_src   <= take_b;
                if (take_b) begin
                    out_data <= b_head;
                    out_idx  <= ib[1:0];
                    ib       <= ib + 3'd1;
                end else begin
                    out_data <= a_head;
                    out_idx  <= ia[1:0];
                    ia       <= ia + 3'd1;
                end
            end
            if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
                ia        <= 3'd0;
                ib        <= 3'd0;
                count     <= 4'd0;
            end
        end
    end

endmodule
